// File: rtl/cache_pkg.sv
// ============================================================================
// cache_pkg : shared cache state encoding and address-field widths
// Rev 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MISS_REQ = 2'd1,
    ST_REFILL   = 2'd2,
    ST_RESP     = 2'd3
  } cache_state_e;

  localparam int ADDR_W         = 32;
  localparam int WORD_BYTE_BITS = 2;

  function automatic int offset_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int lines, input int line_words);
    return ADDR_W - WORD_BYTE_BITS - $clog2(lines) - $clog2(line_words);
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_data_ram.sv
// ============================================================================
// icache_data_ram : LINES x LINE_WORDS x 32 data store, sync read, one write port
// Rev 1.0
// ============================================================================
`default_nettype none

module icache_data_ram #(
  parameter int  LINES      = 64,
  parameter int  LINE_WORDS = 4,
  localparam int AW         = $clog2(LINES * LINE_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [LINES*LINE_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/icache_dm.sv
// ============================================================================
// icache_dm : direct-mapped read-only instruction cache with line refill
// Rev 1.0
// ============================================================================
`default_nettype none

module icache_dm
  import cache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] icache_addr,
  input  logic        icache_re,
  output logic [31:0] icache_dout,
  output logic        stall,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int WB = offset_bits(LINE_WORDS);
  localparam int IB = index_bits(LINES);
  localparam int TB = tag_bits(LINES, LINE_WORDS);
  localparam logic [WB:0] LAST_BEAT = (WB+1)'(LINE_WORDS - 1);

  cache_state_e     state_q, state_d;
  logic             req_re_q, req_re_d;
  logic [29:0]      req_addr_q, req_addr_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TB-1:0]    tag_q [LINES];
  logic             flush_pending_q, flush_pending_d;
  logic             mem_req_valid_q, mem_req_valid_d;
  logic [31:0]      mem_req_addr_q, mem_req_addr_d;
  logic [31:0]      dout_q, dout_d;
  logic [31:0]      fill_word_q, fill_word_d;
  logic [WB:0]      beat_q, beat_d;

  logic [TB-1:0]    req_tag;
  logic [IB-1:0]    req_idx;
  logic [WB-1:0]    req_off;
  logic             lookup, hit, miss, accept;
  logic [31:0]      ram_rdata;
  logic             unused_addr_lsbs;

  assign req_tag = req_addr_q[29 -: TB];
  assign req_idx = req_addr_q[WB +: IB];
  assign req_off = req_addr_q[WB-1:0];

  assign lookup = (state_q == ST_IDLE) && req_re_q;
  assign hit    = lookup && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign miss   = lookup && !hit;
  // The address held by the core during a stall must not be re-accepted.
  assign accept = ((state_q == ST_IDLE) && !miss) || (state_q == ST_RESP);

  assign unused_addr_lsbs = ^icache_addr[1:0];

  icache_data_ram #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_data_ram (
    .clk   (clk),
    .we    ((state_q == ST_REFILL) && mem_resp_valid),
    .waddr ({req_idx, beat_q[WB-1:0]}),
    .wdata (mem_resp_data),
    .re    (accept && icache_re),
    .raddr (icache_addr[2 +: IB+WB]),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d         = state_q;
    req_re_d        = req_re_q;
    req_addr_d      = req_addr_q;
    valid_d         = valid_q;
    flush_pending_d = flush_pending_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    fill_word_d     = fill_word_q;
    beat_d          = beat_q;

    if (accept) begin
      req_re_d   = icache_re;
      req_addr_d = icache_addr[31:2];
    end

    case (state_q)
      ST_IDLE: begin
        if (flush) valid_d = '0;
        if (miss) begin
          state_d         = ST_MISS_REQ;
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = {req_tag, req_idx, {(WB+2){1'b0}}};
        end
      end
      ST_MISS_REQ: begin
        if (flush) flush_pending_d = 1'b1;
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          beat_d          = '0;
          state_d         = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (flush) flush_pending_d = 1'b1;
        if (mem_resp_valid) begin
          beat_d = beat_q + (WB+1)'(1);
          if (beat_q[WB-1:0] == req_off) fill_word_d = mem_resp_data;
          if (beat_q == LAST_BEAT) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        // A flush seen mid-refill wins over marking the new line valid.
        if (flush || flush_pending_q) begin
          valid_d         = '0;
          flush_pending_d = 1'b0;
        end else begin
          valid_d[req_idx] = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    if (hit)                     dout_d = ram_rdata;
    else if (state_q == ST_RESP) dout_d = fill_word_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      req_re_q        <= 1'b0;
      req_addr_q      <= '0;
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      dout_q          <= '0;
      fill_word_q     <= '0;
      beat_q          <= '0;
    end else begin
      state_q         <= state_d;
      req_re_q        <= req_re_d;
      req_addr_q      <= req_addr_d;
      valid_q         <= valid_d;
      flush_pending_q <= flush_pending_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      dout_q          <= dout_d;
      fill_word_q     <= fill_word_d;
      beat_q          <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_RESP) tag_q[req_idx] <= req_tag;
  end

  assign icache_dout   = dout_d;
  assign stall         = miss || (state_q == ST_MISS_REQ) || (state_q == ST_REFILL);
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_dm.sv
// ============================================================================
// tb_icache_dm : vector table + scoreboard bench for icache_dm with a memory responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_icache_dm;

  logic        clk;
  logic        reset;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic [31:0] icache_dout;
  logic        stall;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  icache_dm #(
    .LINES      (64),
    .LINE_WORDS (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .icache_addr    (icache_addr),
    .icache_re      (icache_re),
    .icache_dout    (icache_dout),
    .stall          (stall),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          pre;       // 0 none, 1 idle cycle, 2 idle cycle with flush
    int          flush_at;  // stall cycle in which flush pulses, 0 = never
    int          rwait;     // cycles mem_req_ready is held low
    logic [31:0] exp_dout;
    int          exp_stall;
    logic [31:0] exp_req;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    int          stall;
    logic [31:0] req;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[14];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          ready_wait = 0;
  int          beat_idx = -1;
  logic [31:0] beat_base = '0;
  logic [31:0] last_dout = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0011;
      32'h4:   return 32'h0000_0022;
      32'h8:   return 32'h0000_0033;
      32'hC:   return 32'h0000_0044;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory side: grants after ready_wait cycles, then streams the line back-to-back.
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (beat_idx >= 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_word(beat_base + 32'(4 * beat_idx));
        beat_idx++;
        if (beat_idx == 4) beat_idx = -1;
      end else if (mem_req_valid) begin
        if (ready_wait > 0) begin
          ready_wait--;
        end else begin
          mem_req_ready = 1'b1;
          beat_base     = mem_req_addr;
          beat_idx      = 0;
        end
      end
    end
  end

  task automatic idle_cycle(input bit do_flush);
    icache_re = 1'b0;
    flush     = do_flush;
    @(negedge clk);
    flush = 1'b0;
    check("idle_stall", {31'b0, stall}, 32'h0);
    check("idle_dout_hold", icache_dout, last_dout);
  endtask

  task automatic do_fetch(input vec_t v);
    exp_t e;
    int   cnt;
    if (v.pre != 0) idle_cycle(v.pre == 2);
    ready_wait  = v.rwait;
    icache_re   = 1'b1;
    icache_addr = v.addr;
    e.dout  = v.exp_dout;
    e.stall = v.exp_stall;
    e.req   = v.exp_req;
    sb.push_back(e);
    cnt = 0;
    @(negedge clk);
    while (stall && cnt < 200) begin
      cnt++;
      if (cnt >= 2 && cnt <= 2 + v.rwait) begin
        check("req_valid", {31'b0, mem_req_valid}, 32'h1);
        check("req_addr", mem_req_addr, sb[0].req);
      end
      flush = (cnt == v.flush_at);
      @(negedge clk);
    end
    flush = 1'b0;
    e = sb.pop_front();
    check("stall_cycles", 32'(cnt), 32'(e.stall));
    check("dout", icache_dout, e.dout);
    if (e.stall == 0) check("hit_no_req", {31'b0, mem_req_valid}, 32'h0);
    last_dout = e.dout;
  endtask

  initial begin
    int cnt;
    vec_t rv;

    vecs[0]  = '{32'h0000_0000, 0, 0, 0, 32'h0000_0011, 6,  32'h0000_0000};
    vecs[1]  = '{32'h0000_0008, 1, 0, 0, 32'h0000_0033, 0,  32'h0000_0000};
    vecs[2]  = '{32'h0000_0400, 0, 0, 0, 32'hC0DE_0400, 6,  32'h0000_0400};
    vecs[3]  = '{32'h0000_0004, 0, 0, 0, 32'h0000_0022, 6,  32'h0000_0000};
    vecs[4]  = '{32'h0000_000C, 0, 0, 0, 32'h0000_0044, 0,  32'h0000_0000};
    vecs[5]  = '{32'h0000_0008, 2, 0, 0, 32'h0000_0033, 6,  32'h0000_0000};
    vecs[6]  = '{32'h0000_0010, 0, 4, 0, 32'hC0DE_0010, 6,  32'h0000_0010};
    vecs[7]  = '{32'h0000_0014, 0, 0, 0, 32'hC0DE_0014, 6,  32'h0000_0010};
    vecs[8]  = '{32'h0000_0020, 0, 0, 5, 32'hC0DE_0020, 11, 32'h0000_0020};
    vecs[9]  = '{32'h0000_0024, 0, 0, 0, 32'hC0DE_0024, 0,  32'h0000_0000};
    vecs[10] = '{32'h0000_0000, 0, 0, 0, 32'h0000_0011, 6,  32'h0000_0000};
    vecs[11] = '{32'h0000_03FC, 0, 0, 0, 32'hC0DE_03FC, 6,  32'h0000_03F0};
    vecs[12] = '{32'h0000_03F0, 0, 0, 0, 32'hC0DE_03F0, 0,  32'h0000_0000};
    vecs[13] = '{32'h0000_0030, 0, 0, 0, 32'hC0DE_0030, 6,  32'h0000_0030};

    reset       = 1'b0;
    icache_re   = 1'b0;
    icache_addr = '0;
    flush       = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
    check("rst_req_addr", mem_req_addr, 32'h0);
    check("rst_dout", icache_dout, 32'h0);

    for (int i = 0; i < 13; i++) do_fetch(vecs[i]);

    // Reset lands after two of the four refill beats of line 3.
    icache_re   = 1'b1;
    icache_addr = 32'h0000_0030;
    ready_wait  = 0;
    cnt         = 0;
    @(negedge clk);
    while (stall && cnt < 4) begin
      cnt++;
      @(negedge clk);
    end
    check("rst_mid_stall_cycles", 32'(cnt), 32'd4);
    #1 reset = 1'b0;
    icache_re = 1'b0;
    #1;
    check("rst_mid_stall", {31'b0, stall}, 32'h0);
    check("rst_mid_req_valid", {31'b0, mem_req_valid}, 32'h0);
    check("rst_mid_req_addr", mem_req_addr, 32'h0);
    check("rst_mid_dout", icache_dout, 32'h0);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("late_beat_stall", {31'b0, stall}, 32'h0);
    check("late_beat_req_valid", {31'b0, mem_req_valid}, 32'h0);
    last_dout = 32'h0;
    rv = vecs[13];
    do_fetch(rv);

    icache_re = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
